// File: rtl/matrix_cfg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_cfg_ctrl                                            |
// | Description : Configuration controller for the programmable switch      |
// |               matrix. Per-wire driver-select writes land in a shadow     |
// |               bank. On commit, the shadow bank is optionally scanned     |
// |               for mutual-drive loops. It is then copied atomically into  |
// |               the active bank that feeds drv_sel.                        |
// | Option      : `define MATRIX_CFG_LOOPCHK_EN to include the SCAN state    |
// |               (loop check). Without it, commit goes IDLE -> APPLY.       |
// | Ports       : clk, rst_n     clock / async active-low reset              |
// |               cfg_valid/ready, cfg_wire, cfg_sel   shadow write port     |
// |               commit, clear  single-cycle bank control requests          |
// |               drv_sel        packed active selectors, wire i at          |
// |                              [i*SELW-1:(i-1)*SELW]                       |
// |               busy, done, err, err_code   status                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module matrix_cfg_ctrl #(
  parameter int NWIRES = 18,
  parameter int SELW   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [SELW-1:0]        cfg_wire,
  input  logic [SELW-1:0]        cfg_sel,
  input  logic                   commit,
  input  logic                   clear,
  output logic [NWIRES*SELW-1:0] drv_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam logic [SELW-1:0] NW_SEL = SELW'(NWIRES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef MATRIX_CFG_LOOPCHK_EN
    ST_SCAN  = 2'd1,
`endif
    ST_APPLY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  // Entry j of each bank holds the selector for wire j+1.
  logic [SELW-1:0] shadow_q [NWIRES];
  logic [SELW-1:0] shadow_d [NWIRES];
  logic [SELW-1:0] active_q [NWIRES];
  logic [SELW-1:0] active_d [NWIRES];
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

`ifdef MATRIX_CFG_LOOPCHK_EN
  logic [SELW-1:0] scan_idx_q, scan_idx_d;
  logic [SELW-1:0] scan_sel;
  logic [SELW-1:0] scan_back;

  // scan_sel = shadow[i]; scan_back = shadow[scan_sel]. Both use decoded
  // lookups, so a zero or out-of-range index reads as 0 and never aliases.
  always_comb begin
    scan_sel  = '0;
    scan_back = '0;
    for (int j = 0; j < NWIRES; j++) begin
      if (scan_idx_q == SELW'(j + 1)) scan_sel = shadow_q[j];
    end
    for (int j = 0; j < NWIRES; j++) begin
      if (scan_sel == SELW'(j + 1)) scan_back = shadow_q[j];
    end
  end
`endif

  assign cfg_ready = (state_q == ST_IDLE) & ~clear;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
`ifdef MATRIX_CFG_LOOPCHK_EN
    scan_idx_d = scan_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          // clear wins over any write or commit presented in the same cycle
          for (int j = 0; j < NWIRES; j++) shadow_d[j] = '0;
        end else begin
          if (cfg_valid) begin
            if (cfg_wire == '0 || cfg_wire > NW_SEL) begin
              err_d      = 1'b1;
              err_code_d = 2'd1;
            end else if (cfg_sel > NW_SEL || cfg_sel == cfg_wire) begin
              err_d      = 1'b1;
              err_code_d = 2'd2;
            end else begin
              for (int j = 0; j < NWIRES; j++) begin
                if (cfg_wire == SELW'(j + 1)) shadow_d[j] = cfg_sel;
              end
            end
          end
          if (commit) begin
`ifdef MATRIX_CFG_LOOPCHK_EN
            state_d    = ST_SCAN;
            scan_idx_d = SELW'(1);
`else
            state_d    = ST_APPLY;
`endif
          end
        end
      end
`ifdef MATRIX_CFG_LOOPCHK_EN
      ST_SCAN: begin
        if (scan_sel != '0 && scan_back == scan_idx_q) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = ST_IDLE;
        end else if (scan_idx_q == NW_SEL) begin
          state_d = ST_APPLY;
        end else begin
          scan_idx_d = scan_idx_q + SELW'(1);
        end
      end
`endif
      ST_APPLY: begin
        active_d = shadow_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      for (int j = 0; j < NWIRES; j++) begin
        shadow_q[j] <= '0;
        active_q[j] <= '0;
      end
`ifdef MATRIX_CFG_LOOPCHK_EN
      scan_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
`ifdef MATRIX_CFG_LOOPCHK_EN
      scan_idx_q <= scan_idx_d;
`endif
    end
  end

  for (genvar g = 0; g < NWIRES; g++) begin : g_pack
    assign drv_sel[g*SELW +: SELW] = active_q[g];
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
`default_nettype wire
